// File: rtl/core_run_ctrl.sv
// core_run_ctrl
// ---------------------------------------------------------------------------
// Run controller for the single-cycle RISC-V core. After `start` it holds the
// core in reset for RST_CYCLES cycles, then lets it run until one of three
// things happens: the core raises halt_i, the PC stops moving for STALL_LIMIT
// cycles (optional), or the cycle budget MAX_CYCLES is used up. The cause
// and the number of completed RUN cycles are latched for inspection.
//
// Optional feature macro: CORE_RUN_CTRL_STALL_DET_EN
//   defined   -> PC-stall detection is built and can end a run
//   undefined -> pc_i is ignored and `stalled` stays 0
//
// Ports
//   clk          in   1      single clock, rising edge
//   rst          in   1      synchronous, active-high reset
//   start        in   1      begin a run (sampled in IDLE or DONE only)
//   halt_i       in   1      core halt indication (used in RUN only)
//   pc_i         in   PC_W   core program counter
//   core_rst_n   out  1      active-low reset to the core
//   core_en      out  1      core advance enable, high only in RUN
//   running      out  1      high in RUN
//   done         out  1      high in DONE
//   halted       out  1      run ended by halt_i
//   stalled      out  1      run ended by PC stall
//   timeout      out  1      run ended by cycle budget
//   cycle_count  out  CNT_W  completed RUN cycles
//   fsm_state    out  2      current FSM state (debug)
//
// Handshake: `start` is a level sampled on a rising edge while the FSM is in
// IDLE or DONE; it is ignored in every other state. All outputs are
// registered, so no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module core_run_ctrl #(
   parameter int RST_CYCLES  = 3,
   parameter int MAX_CYCLES  = 1000,
   parameter int CNT_W       = 16,
   parameter int PC_W        = 32,
   parameter int STALL_LIMIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             halt_i,
   input  logic [PC_W-1:0]  pc_i,
   output logic             core_rst_n,
   output logic             core_en,
   output logic             running,
   output logic             done,
   output logic             halted,
   output logic             stalled,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_count,
   output logic [1:0]       fsm_state
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RESET = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // Reset counter counts RST_CYCLES-1 down to 0, one step per RESET cycle.
   localparam int              RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RCW-1:0]  RST_LOAD = RCW'(RST_CYCLES - 1);

   // Comparing against MAX_CYCLES-1 is the same as cycle_count+1 == MAX_CYCLES
   // without needing an extra bit for the sum.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

   logic [1:0]     state;
   logic [RCW-1:0] rst_cnt;
   logic           stall_hit;
   logic           budget_hit;
   logic           run_exit;
   logic           launch;

   assign fsm_state  = state;
   assign launch     = start && ((state == S_IDLE) || (state == S_DONE));
   assign budget_hit = (cycle_count == CNT_LAST);
   assign run_exit   = halt_i || stall_hit || budget_hit;

`ifdef CORE_RUN_CTRL_STALL_DET_EN
   localparam int SCW = $clog2(STALL_LIMIT + 1);

   logic [SCW-1:0]  stall_cnt;
   logic [SCW-1:0]  stall_next;
   logic [PC_W-1:0] pc_last;

   // cycle_count == 0 marks the first RUN cycle: pc_last has no valid
   // history yet, so that cycle only loads it.
   always_comb begin
      stall_next = '0;
      if ((cycle_count != '0) && (pc_i == pc_last)) begin
         stall_next = stall_cnt + 1'b1;
      end
   end

   // Fires in the same cycle the counter would reach the limit.
   assign stall_hit = (state == S_RUN) && (stall_next == SCW'(STALL_LIMIT));

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         pc_last   <= '0;
      end else if (launch) begin
         stall_cnt <= '0;
         pc_last   <= '0;
      end else if (state == S_RUN) begin
         stall_cnt <= stall_next;
         pc_last   <= pc_i;
      end
   end
`else
   logic unused_pc;
   assign unused_pc = ^pc_i;
   assign stall_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         rst_cnt     <= '0;
         core_rst_n  <= 1'b0;
         core_en     <= 1'b0;
         running     <= 1'b0;
         done        <= 1'b0;
         halted      <= 1'b0;
         stalled     <= 1'b0;
         timeout     <= 1'b0;
         cycle_count <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               // DONE keeps the core out of reset so its state can be read;
               // a new start puts it back into reset and clears the result.
               if (start) begin
                  state       <= S_RESET;
                  rst_cnt     <= RST_LOAD;
                  core_rst_n  <= 1'b0;
                  core_en     <= 1'b0;
                  running     <= 1'b0;
                  done        <= 1'b0;
                  halted      <= 1'b0;
                  stalled     <= 1'b0;
                  timeout     <= 1'b0;
                  cycle_count <= '0;
               end
            end

            S_RESET: begin
               if (rst_cnt == '0) begin
                  state      <= S_RUN;
                  core_rst_n <= 1'b1;
                  core_en    <= 1'b1;
                  running    <= 1'b1;
               end else begin
                  rst_cnt <= rst_cnt - 1'b1;
               end
            end

            S_RUN: begin
               cycle_count <= cycle_count + 1'b1;
               if (run_exit) begin
                  state   <= S_DONE;
                  core_en <= 1'b0;
                  running <= 1'b0;
                  done    <= 1'b1;
                  // Priority halt > stall > budget keeps exactly one cause set.
                  halted  <= halt_i;
                  stalled <= !halt_i && stall_hit;
                  timeout <= !halt_i && !stall_hit;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Testbench for core_run_ctrl with RST_CYCLES=3, MAX_CYCLES=20, STALL_LIMIT=4.
// Run scenarios come from a table of {stimulus, expected result} records;
// reset, idle behaviour, start-during-RESET and mid-run reset are
// hand-written sequences.
module tb_core_run_ctrl;

   localparam int RST_CYCLES  = 3;
   localparam int MAX_CYCLES  = 20;
   localparam int CNT_W       = 16;
   localparam int PC_W        = 32;
   localparam int STALL_LIMIT = 4;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RESET = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             halt_i;
   logic [PC_W-1:0]  pc_i;
   logic             core_rst_n;
   logic             core_en;
   logic             running;
   logic             done;
   logic             halted;
   logic             stalled;
   logic             timeout;
   logic [CNT_W-1:0] cycle_count;
   logic [1:0]       fsm_state;

   always #5 clk = ~clk;

   core_run_ctrl #(
      .RST_CYCLES (RST_CYCLES),
      .MAX_CYCLES (MAX_CYCLES),
      .CNT_W      (CNT_W),
      .PC_W       (PC_W),
      .STALL_LIMIT(STALL_LIMIT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .halt_i     (halt_i),
      .pc_i       (pc_i),
      .core_rst_n (core_rst_n),
      .core_en    (core_en),
      .running    (running),
      .done       (done),
      .halted     (halted),
      .stalled    (stalled),
      .timeout    (timeout),
      .cycle_count(cycle_count),
      .fsm_state  (fsm_state)
   );

   // ---------------- scoreboard counters ----------------
   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scenario table ----------------
   typedef struct {
      string name;
      int    halt_at;   // RUN cycle (cycle_count value) to raise halt_i; -1 = never
      bit    hold_pc;   // hold pc_i = 0x40 from RUN cycle 2 on
      bit    exp_halted;
      bit    exp_stalled;
      bit    exp_timeout;
      int    exp_count;
   } scen_t;

   scen_t scen[6];

   // Launches a run from IDLE/DONE and drives it to DONE, checking
   // the reset window length and the final latched result.
   task automatic run_scenario(input scen_t s);
      int n;
      int k;
      logic [CNT_W-1:0] held_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      check({s.name, ".enter_reset"}, 32'(fsm_state), 32'(S_RESET));
      check({s.name, ".flags_clear"}, {29'd0, halted, stalled, timeout}, 32'd0);
      check({s.name, ".count_clear"}, 32'(cycle_count), 32'd0);
      n = 0;
      while (core_rst_n == 1'b0 && n < 20) begin
         n++;
         tick();
      end
      check({s.name, ".rst_low_cycles"}, n, RST_CYCLES);
      check({s.name, ".first_run_cycle"}, {30'd0, running, core_en}, 32'd3);
      k = 0;
      while (running === 1'b1 && k < 60) begin
         check({s.name, ".run_count"}, 32'(cycle_count), k);
         pc_i   = (s.hold_pc && k >= 2) ? 32'h40 : 32'(k * 4);
         halt_i = (k == s.halt_at);
         tick();
         k++;
      end
      halt_i = 1'b0;
      check({s.name, ".done"}, {29'd0, done, core_en, core_rst_n}, 32'b101);
      check({s.name, ".state_done"}, 32'(fsm_state), 32'(S_DONE));
      check({s.name, ".cause"}, {29'd0, halted, stalled, timeout},
            {29'd0, s.exp_halted, s.exp_stalled, s.exp_timeout});
      check({s.name, ".cycle_count"}, 32'(cycle_count), s.exp_count);
      // Result must stay put while in DONE, whatever the core inputs do.
      held_cnt = cycle_count;
      halt_i = 1'b1;
      pc_i   = $urandom_range(0, 255);
      tick();
      tick();
      halt_i = 1'b0;
      check({s.name, ".done_hold"}, {13'd0, done, halted, stalled, timeout, cycle_count},
            {13'd0, 1'b1, s.exp_halted, s.exp_stalled, s.exp_timeout, held_cnt});
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n;
      rst    = 1'b1;
      start  = 1'b0;
      halt_i = 1'b0;
      pc_i   = '0;

      scen[0] = '{"halt7",    7,  1'b0, 1'b1, 1'b0, 1'b0, 8};
      scen[1] = '{"timeout", -1,  1'b0, 1'b0, 1'b0, 1'b1, 20};
`ifdef CORE_RUN_CTRL_STALL_DET_EN
      // Same PC seen in cycles 3,4,5,6 -> counter hits 4 in cycle 6.
      scen[2] = '{"stall",   -1,  1'b1, 1'b0, 1'b1, 1'b0, 7};
`else
      scen[2] = '{"stall",   -1,  1'b1, 1'b0, 1'b0, 1'b1, 20};
`endif
      scen[3] = '{"halt_at_budget", 19, 1'b0, 1'b1, 1'b0, 1'b0, 20};
      scen[4] = '{"halt_first",      0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
      scen[5] = '{"halt_over_stall", 6, 1'b1, 1'b1, 1'b0, 1'b0, 7};

      // Reset: two cycles of rst.
      tick();
      tick();
      rst = 1'b0;
      check("reset.state", 32'(fsm_state), 32'(S_IDLE));
      check("reset.outputs",
            {24'd0, core_rst_n, core_en, running, done, halted, stalled, timeout, 1'b0}, 32'd0);
      check("reset.count", 32'(cycle_count), 32'd0);

      // IDLE with start low: nothing moves, halt_i and pc_i have no effect.
      for (int i = 0; i < 10; i++) begin
         halt_i = 1'(i & 1);
         pc_i   = $urandom_range(0, 1023);
         tick();
         check("idle.stay", {27'd0, fsm_state, core_rst_n, running, done}, {27'd0, S_IDLE, 3'b000});
      end
      halt_i = 1'b0;

      // Table-driven runs; each after the first restarts from DONE.
      for (int i = 0; i < 6; i++) begin
         run_scenario(scen[i]);
      end

      // start held through RESET must not stretch it; then reset mid-run.
      start = 1'b1;
      tick();
      check("midrst.enter_reset", 32'(fsm_state), 32'(S_RESET));
      n = 0;
      while (core_rst_n == 1'b0 && n < 20) begin
         n++;
         tick();
      end
      start = 1'b0;
      check("midrst.rst_low_cycles", n, RST_CYCLES);
      for (int k = 0; k < 5; k++) begin
         pc_i = 32'(k * 4);
         tick();
      end
      check("midrst.count5", 32'(cycle_count), 32'd5);
      check("midrst.running", {31'd0, running}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst.state", 32'(fsm_state), 32'(S_IDLE));
      check("midrst.count", 32'(cycle_count), 32'd0);
      check("midrst.outputs",
            {25'd0, core_rst_n, core_en, running, done, halted, stalled, timeout}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Watchdog: the whole run is a few hundred cycles.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
